// File: rtl/auto_drive_sequencer.sv
// Semi-auto driving sequencer: turns detector bits and driver choices into the UART command byte.
// Optional AUTO_UTURN_EN: a dead end triggers an automatic U-turn instead of stopping.
module auto_drive_sequencer #(
  parameter int unsigned TURN_CYCLES = 90_000_000,
  parameter int unsigned COOL_CYCLES = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       front_det,
  input  logic       left_det,
  input  logic       right_det,
  input  logic       back_det,
  input  logic       dir_left,
  input  logic       dir_right,
  input  logic       dir_straight,
  output logic [7:0] cmd,
  output logic [2:0] state_out,
  output logic       turning,
  output logic       junction_wait
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StForward  = 3'd1;
  localparam logic [2:0] StWaitDir  = 3'd2;
  localparam logic [2:0] StTurnL    = 3'd3;
  localparam logic [2:0] StTurnR    = 3'd4;
  localparam logic [2:0] StTurnBack = 3'd5;
  localparam logic [2:0] StCooldown = 3'd6;
  localparam logic [2:0] StStop     = 3'd7;

  localparam logic [31:0] TurnLast = 32'(TURN_CYCLES - 1);
  localparam logic [31:0] BackLast = 32'(2 * TURN_CYCLES - 1);
  localparam logic [31:0] CoolLast = 32'(COOL_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        open_f, open_l, open_r;
  logic        timed;

  // Reserved input, not used by the sequencing.
  logic unused_back_det;
  assign unused_back_det = back_det;

  assign open_f = ~front_det;
  assign open_l = ~left_det;
  assign open_r = ~right_det;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StForward;
      StForward: begin
        if (open_f && !open_l && !open_r) begin
          state_d = StForward;
        end else if ((open_f && open_l) || (open_f && open_r) || (open_l && open_r)) begin
          state_d = StWaitDir;
        end else if (open_l) begin
          state_d = StTurnL;
        end else if (open_r) begin
          state_d = StTurnR;
        end else begin
`ifdef AUTO_UTURN_EN
          state_d = StTurnBack;
`else
          state_d = StStop;
`endif
        end
      end
      StWaitDir: begin
        // Requests for blocked paths are skipped, so a lower-priority open one can win.
        if (dir_left && open_l) begin
          state_d = StTurnL;
        end else if (dir_right && open_r) begin
          state_d = StTurnR;
        end else if (dir_straight && open_f) begin
          state_d = StCooldown;
        end
      end
      StTurnL, StTurnR: begin
        if (cnt_q == TurnLast) state_d = StCooldown;
      end
      StTurnBack: begin
        if (cnt_q == BackLast) state_d = StCooldown;
      end
      StCooldown: begin
        if (front_det || cnt_q == CoolLast) state_d = StForward;
      end
      StStop: state_d = StStop;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  assign timed = (state_q == StTurnL) || (state_q == StTurnR) ||
                 (state_q == StTurnBack) || (state_q == StCooldown);

  always_comb begin
    cnt_d = 32'd0;
    if (state_d == state_q && timed) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cmd = 8'h80;
    unique case (state_q)
      StForward, StCooldown: cmd = 8'h81;
      StTurnL, StTurnBack:   cmd = 8'h84;
      StTurnR:               cmd = 8'h88;
      default:               cmd = 8'h80;
    endcase
  end

  assign state_out     = state_q;
  assign turning       = (state_q == StTurnL) || (state_q == StTurnR) || (state_q == StTurnBack);
  assign junction_wait = (state_q == StWaitDir);

endmodule

// File: doc/auto_drive_sequencer.md
# auto_drive_sequencer

Semi-automatic driving controller that sequences the car's 8-bit UART command byte from the four detector bits and the driver's direction choice at junctions. It drives forward down corridors, takes forced single-exit turns by itself, waits for a driver choice at multi-exit junctions, and times the turns. It sits between the detector return byte of the UART link and the command byte sent to the simulator. It is used when the top level selects semi-auto mode in place of the manual datapath.

## Interface
Parameters:
- TURN_CYCLES, 90_000_000: sys_clk cycles of left/right turn command for a 90° turn (0.9 s at 100 MHz).
- COOL_CYCLES, 50_000_000: cycles of forced forward after a turn or straight choice, with side detectors ignored.

Ports (reset rst, asynchronous, active-low; clock sys_clk):
- sys_clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  semi-auto mode active; low forces IDLE.
- front_det, left_det, right_det, back_det  in  1 each  detector bits, sys_clk-synchronous; 1 = blocked, 0 = open.
- dir_left, dir_right, dir_straight  in  1 each  driver direction request, level, sys_clk-synchronous.
- cmd  out  8  command byte {2'b10, destroy, place, right, left, back, fwd}.
- state_out  out  3  current state encoding.
- turning  out  1  high in TURN_L, TURN_R and TURN_BACK.
- junction_wait  out  1  high in WAIT_DIR.

## Operation
- State encoding: IDLE=0, FORWARD=1, WAIT_DIR=2, TURN_L=3, TURN_R=4, TURN_BACK=5, COOLDOWN=6, STOP=7.
- cmd is a pure decode of the state register:
  - 8'h80 in IDLE, WAIT_DIR and STOP.
  - 8'h81 in FORWARD and COOLDOWN.
  - 8'h84 in TURN_L and TURN_BACK.
  - 8'h88 in TURN_R.
  - Destroy, place and back bits are always 0.
- enable=0 in any state: next state IDLE and counter cleared. This overrides every other transition.
- IDLE: if enable=1, go to FORWARD.
- FORWARD: let L = ~left_det, R = ~right_det, F = ~front_det.
  - F & ~L & ~R: stay in FORWARD.
  - Two or more of {F, L, R} open: go to WAIT_DIR.
  - Exactly L open (front blocked): go to TURN_L.
  - Exactly R open (front blocked): go to TURN_R.
  - None open: dead end, handled per Configuration.
- WAIT_DIR: accept requests with priority dir_left > dir_right > dir_straight. A request is honoured only if its path is open at that cycle; a request for a blocked path is ignored and the state holds.
  - left goes to TURN_L, right goes to TURN_R, straight goes to COOLDOWN.
- TURN_L / TURN_R: exit to COOLDOWN after the turn duration (see Timing).
- TURN_BACK: left-turn command for 2·TURN_CYCLES, then go to COOLDOWN.
- COOLDOWN: forward for COOL_CYCLES, then go to FORWARD. If front_det=1 during COOLDOWN, go to FORWARD on the next edge, which re-evaluates.
- STOP: hold until enable=0.
- back_det is unused by the sequencing and is reserved.
- Counter: 32-bit. Cleared on every state change, increments each cycle within a timed state.

## Timing
- Reset values:
  - state=IDLE, counter=0.
  - cmd=8'h80, state_out=0, turning=0, junction_wait=0.
- Inputs are sampled at the posedge. A transition is visible on state_out, cmd and the flags right after that edge, so latency is 1 cycle from input to output.
- Timed states last exactly N cycles: the counter starts at 0 on entry, and the exit transition is taken when counter == N−1.
  - N = TURN_CYCLES for TURN_L/TURN_R.
  - N = 2·TURN_CYCLES for TURN_BACK.
  - N = COOL_CYCLES for COOLDOWN.
- Simultaneous events:
  - enable=0 beats counter expiry.
  - front_det=1 in COOLDOWN beats expiry.
  - Several dir_* requests resolve by priority in a single cycle.
- Reset mid-turn: immediate IDLE with cmd=8'h80. There is no resume.

## Configuration
- AUTO_UTURN_EN defined: a dead end in FORWARD goes to TURN_BACK.
- AUTO_UTURN_EN undefined: a dead end goes to STOP, and state 5 is unreachable.

## Test plan
- Use TURN_CYCLES=8 and COOL_CYCLES=4 on the bench.
- Reset with enable=1 and all detectors open, then release: IDLE for 1 edge → FORWARD with cmd=8'h81; front=1, left=1, right=1 held → WAIT_DIR? No: F=0, L=0, R=0 → dead end; with AUTO_UTURN_EN: cmd=8'h84 for exactly 16 cycles, then 8'h81 for 4 cycles, then FORWARD; without it: STOP with cmd=8'h80.
- FORWARD, front=1, left=0, right=1 → TURN_L, turning=1, cmd=8'h84 for 8 cycles → COOLDOWN 8'h81 for 4 cycles → FORWARD.
- All paths open → WAIT_DIR, junction_wait=1, cmd=8'h80; dir_right=1 with right_det=1 → holds; then right_det=0 → TURN_R, cmd=8'h88.
- In WAIT_DIR, dir_left=dir_right=dir_straight=1 with all paths open → TURN_L; repeat with left_det=1 → TURN_R.
- Deassert enable at turn cycle 3 → IDLE next edge, cmd=8'h80. Assert rst low mid-COOLDOWN → outputs go to reset values asynchronously.
